mdu_seq: RTL



---
 rtl/mdu_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit with its own HI/LO pair.
// Decodes the R-type funct field for mult, multu, div, divu, mthi and mtlo.
// Multiply and divide are radix-2 iterative, with a start/busy/done handshake.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request strobe, sampled on a rising clk edge
//   funct    R-type funct field, sampled with start
//   a        rs operand: multiplicand, dividend, or mthi/mtlo source
//   b        rt operand: multiplier or divisor
//   busy     high while an operation is in flight; start is ignored while high
//   done     one-cycle pulse when hi/lo hold a new result
//   div0     high together with done when a div/divu had b == 0
//   illegal  one-cycle pulse after a start with an unsupported funct
//   hi, lo   HI and LO registers
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   b_raw;
    logic [WIDTH-1:0]   mcand;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;
    logic               is_div;
    logic               is_signed;
    logic               res_neg;
    logic               rem_neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        a_mag = (is_signed && a_raw[WIDTH-1]) ? -a_raw : a_raw;
        b_mag = (is_signed && b_raw[WIDTH-1]) ? -b_raw : b_raw;

        // multiply: add multiplicand into the upper half when the LSB is set, then shift right
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        // divide: shifted partial remainder minus divisor; borrow means restore
        trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mcand};

        if (is_div) begin
            if (trial[WIDTH])
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            else
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end

        prod_fix = res_neg ? -acc_next : acc_next;
        quo_fix  = res_neg ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        rem_fix  = rem_neg ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_raw     <= '0;
            b_raw     <= '0;
            mcand     <= '0;
            acc       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            res_neg   <= 1'b0;
            rem_neg   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div0      <= 1'b0;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done    <= 1'b0;
            div0    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (funct)
                            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                                a_raw     <= a;
                                b_raw     <= b;
                                is_div    <= funct[1];
                                is_signed <= ~funct[0];
                                busy      <= 1'b1;
                                state     <= PREP;
                            end
                            F_MTHI: begin
                                hi   <= a;
                                done <= 1'b1;
                            end
                            F_MTLO: begin
                                lo   <= a;
                                done <= 1'b1;
                            end
                            default: illegal <= 1'b1;
                        endcase
                    end
                end
                PREP: begin
                    if (is_div) begin
                        acc   <= {{WIDTH{1'b0}}, a_mag};
                        mcand <= b_mag;
                    end else begin
                        acc   <= {{WIDTH{1'b0}}, b_mag};
                        mcand <= a_mag;
                    end
                    res_neg <= is_signed & (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
                    rem_neg <= is_signed & a_raw[WIDTH-1];
                    cnt     <= CNT_W'(WIDTH);
                    state   <= RUN;
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    // RUN covers WIDTH-1 iterations; FIX performs the last one
                    // together with sign correction to meet the WIDTH+2 latency.
                    if (cnt == CNT_W'(2))
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        if (b_raw == '0) begin
                            hi   <= a_raw;
                            lo   <= '1;
                            div0 <= 1'b1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    acc   <= acc_next;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
